// File: rtl/alu_iterative_exec.sv
// alu_iterative_exec
// ------------------
// Execution-side ALU that consumes the 4-bit alu_op from ALU control decode.
// Logic ops, add/sub and branch compares finish in one cycle. SLL/SRL run
// through a 1-bit-per-cycle iterative shifter.
//
// Handshake (both sides, strict valid/ready):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   Input side: in_ready is 1 only in IDLE. The requester holds in_valid and
//   its operands stable until in_ready is seen high. Operands are captured
//   only on the accept edge.
//   Output side: out_valid is 1 only in DONE. alu_result, alu_bcond and
//   alu_err stay stable until the edge where out_ready is 1.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   in_valid        request present
//   in_ready        block can accept a request (IDLE)
//   alu_op          4-bit operation code; 4'b1111 and unlisted codes are errors
//   alu_in_1        operand A
//   alu_in_2        operand B; shift amount taken from [SHAMT_WIDTH-1:0]
//   out_valid       result available (DONE)
//   out_ready       consumer takes the result
//   alu_result      registered result
//   alu_bcond       registered branch-taken flag
//   alu_err         registered invalid-opcode flag
//   dbg_state       current FSM state (0=IDLE, 1=SHIFT, 2=DONE)
module alu_iterative_exec #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_in_1,
  input  logic [DATA_WIDTH-1:0] alu_in_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  alu_bcond,
  output logic                  alu_err,
  output logic [1:0]            dbg_state
);

  // Opcode encodings (must match alu_opcodes.v).
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SLL = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_BEQ = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1011;
  localparam logic [3:0] OP_BLT = 4'b1100;
  localparam logic [3:0] OP_BGE = 4'b1101;

  localparam logic [SHAMT_WIDTH-1:0] CNT_ONE  = {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SHAMT_WIDTH-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   acc_q;
  logic [SHAMT_WIDTH-1:0]  cnt_q;
  logic                    shift_left_q;

  logic [SHAMT_WIDTH-1:0]  shamt;
  logic                    is_shift;
  logic                    start_shift;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   single_res;
  logic                    single_bcond;
  logic                    single_err;
  logic [DATA_WIDTH-1:0]   acc_shifted;

  assign shamt       = alu_in_2[SHAMT_WIDTH-1:0];
  assign is_shift    = (alu_op == OP_SLL) || (alu_op == OP_SRL);
  // Shift by zero skips the SHIFT state and completes like a single-cycle op.
  assign start_shift = is_shift && (shamt != CNT_ZERO);
  assign accept      = (state_q == IDLE) && in_valid;
  assign acc_shifted = shift_left_q ? (acc_q << 1) : (acc_q >> 1);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dbg_state = state_q;

  // Single-cycle result, evaluated on the live inputs at the accept edge.
  always_comb begin
    single_res   = '0;
    single_bcond = 1'b0;
    single_err   = 1'b0;
    case (alu_op)
      OP_ADD: single_res = alu_in_1 + alu_in_2;
      OP_SUB: single_res = alu_in_1 - alu_in_2;
      OP_XOR: single_res = alu_in_1 ^ alu_in_2;
      OP_OR:  single_res = alu_in_1 | alu_in_2;
      OP_AND: single_res = alu_in_1 & alu_in_2;
      OP_SLL,
      OP_SRL: single_res = alu_in_1;
      OP_BEQ: begin
        single_res   = alu_in_1 - alu_in_2;
        single_bcond = (alu_in_1 == alu_in_2);
      end
      OP_BNE: begin
        single_res   = alu_in_1 - alu_in_2;
        single_bcond = (alu_in_1 != alu_in_2);
      end
      OP_BLT: begin
        single_res   = alu_in_1 - alu_in_2;
        single_bcond = ($signed(alu_in_1) < $signed(alu_in_2));
      end
      OP_BGE: begin
        single_res   = alu_in_1 - alu_in_2;
        single_bcond = ($signed(alu_in_1) >= $signed(alu_in_2));
      end
      default: single_err = 1'b1;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = start_shift ? SHIFT : DONE;
      SHIFT:   if (cnt_q == CNT_ONE) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers. Result registers change only on an accept edge or
  // on the final shift edge, so they are naturally held during DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      shift_left_q <= 1'b0;
      alu_result   <= '0;
      alu_bcond    <= 1'b0;
      alu_err      <= 1'b0;
    end else begin
      if (accept) begin
        if (start_shift) begin
          acc_q        <= alu_in_1;
          cnt_q        <= shamt;
          shift_left_q <= (alu_op == OP_SLL);
        end else begin
          alu_result <= single_res;
          alu_bcond  <= single_bcond;
          alu_err    <= single_err;
        end
      end else if (state_q == SHIFT) begin
        acc_q <= acc_shifted;
        cnt_q <= cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          alu_result <= acc_shifted;
          alu_bcond  <= 1'b0;
          alu_err    <= 1'b0;
        end
      end
    end
  end

endmodule
